// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 paddle-key input stage.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam logic [7:0] DEF_CODE_P1_UP   = 8'h1D;
  localparam logic [7:0] DEF_CODE_P1_DOWN = 8'h1B;
  localparam logic [7:0] DEF_CODE_P2_UP   = 8'h75;
  localparam logic [7:0] DEF_CODE_P2_DOWN = 8'h72;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 5000;

  // A frame is accepted when the stop bit is high and data+parity has odd weight.
  function automatic logic frame_ok(input logic [7:0] data, input logic parity,
                                    input logic stop);
    return stop & (^{data, parity});
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronizers, clock fall detect, framing FSM and
// inter-edge timeout. Results are combinational in the stop-bit fall cycle.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] data_c,
  output logic       valid_c,
  output logic       err_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic clk_meta, clk_sync, clk_prev;
  logic dat_meta, dat_sync;
  logic fall;

  rx_state_t        state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic             par_q, par_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Two-flop synchronizers plus one history flop on the clock for edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      clk_prev <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= ps2_clk;
      clk_sync <= clk_meta;
      clk_prev <= clk_sync;
      dat_meta <= ps2_dat;
      dat_sync <= dat_meta;
    end
  end

  assign fall = clk_prev & ~clk_sync;

  // Receiver state and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= 8'h00;
      bitcnt_q <= 3'd0;
      par_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      par_q    <= par_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic; a fall always wins over a timeout in the same cycle.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    par_d    = par_q;
    cnt_d    = fall ? '0 : cnt_q + CNT_W'(1);
    valid_c  = 1'b0;
    err_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) begin
          if (!dat_sync) begin
            state_d  = DATA;
            bitcnt_d = 3'd0;
            shift_d  = 8'h00;
          end else begin
            err_c = 1'b1;
          end
        end
      end
      DATA: begin
        if (fall) begin
          shift_d  = {dat_sync, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_d   = dat_sync;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (frame_ok(shift_q, par_q, dat_sync)) valid_c = 1'b1;
          else                                    err_c   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Host stalled mid-frame: drop the partial byte.
    if (state_q != IDLE && !fall && cnt_q == CNT_LAST) begin
      state_d = IDLE;
      cnt_d   = '0;
      err_c   = 1'b1;
    end
  end

  assign data_c = shift_q;

endmodule

// File: rtl/ps2_paddle_keys.sv
// PS/2 keyboard front end for pong: decodes make/break/extended scan codes
// into held-key levels for both players' bats.
module ps2_paddle_keys
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [7:0]  CODE_P1_UP     = DEF_CODE_P1_UP,
  parameter logic [7:0]  CODE_P1_DOWN   = DEF_CODE_P1_DOWN,
  parameter logic [7:0]  CODE_P2_UP     = DEF_CODE_P2_UP,
  parameter logic [7:0]  CODE_P2_DOWN   = DEF_CODE_P2_DOWN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       p1_up,
  output logic       p1_down,
  output logic       p2_up,
  output logic       p2_down,
  output logic [7:0] scan_code,
  output logic       scan_ready,
  output logic       frame_err
);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       ext;
  logic       brk;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk    (clk),
    .reset  (reset),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .data_c (rx_data),
    .valid_c(rx_valid),
    .err_c  (rx_err)
  );

  // Decode each received byte; prefixes arm ext/brk for the following code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_up      <= 1'b0;
      p1_down    <= 1'b0;
      p2_up      <= 1'b0;
      p2_down    <= 1'b0;
      scan_code  <= 8'h00;
      scan_ready <= 1'b0;
      frame_err  <= 1'b0;
      ext        <= 1'b0;
      brk        <= 1'b0;
    end else begin
      scan_ready <= rx_valid;
      frame_err  <= rx_err;
      if (rx_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (rx_valid) begin
        scan_code <= rx_data;
        if (rx_data == PS2_EXT) begin
          ext <= 1'b1;
        end else if (rx_data == PS2_BRK) begin
          brk <= 1'b1;
        end else begin
          if (rx_data == CODE_P1_UP   && !ext) p1_up   <= ~brk;
          if (rx_data == CODE_P1_DOWN && !ext) p1_down <= ~brk;
          if (rx_data == CODE_P2_UP   &&  ext) p2_up   <= ~brk;
          if (rx_data == CODE_P2_DOWN &&  ext) p2_down <= ~brk;
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_paddle_keys.sv
// Directed bench for ps2_paddle_keys: bit-bangs PS/2 frames and checks
// scan_code, pulse timing and key levels against hand-derived values.
module tb_ps2_paddle_keys;
  import ps2_pkg::*;

  localparam int unsigned TO   = 5000;
  localparam int unsigned HALF = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       p1_up, p1_down, p2_up, p2_down;
  logic [7:0] scan_code;
  logic       scan_ready;
  logic       frame_err;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         rdy_cnt = 0;
  int         err_cnt = 0;
  int         snap_rdy;
  int         snap_err;
  logic [3:0] lv;  // expected {p1_up, p1_down, p2_up, p2_down}

  ps2_paddle_keys #(.TIMEOUT_CYCLES(TO)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .p1_up     (p1_up),
    .p1_down   (p1_down),
    .p2_up     (p2_up),
    .p2_down   (p2_down),
    .scan_code (scan_code),
    .scan_ready(scan_ready),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Pulse counters for whole-test accounting.
  always @(negedge clk) begin
    if (scan_ready === 1'b1) rdy_cnt++;
    if (frame_err === 1'b1)  err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present a bit while ps2_clk is high, then drop ps2_clk (returns on the fall).
  task automatic fall_bit(input logic b);
    ps2_dat = b;
    wait_neg(HALF);
    ps2_clk = 1'b0;
  endtask

  task automatic rise();
    wait_neg(HALF);
    ps2_clk = 1'b1;
  endtask

  // Full 11-bit frame followed by cycle-exact checks around the stop-bit fall.
  task automatic frame(input string tag, input logic [7:0] d, input logic par_ok,
                       input logic stop, input logic exp_rdy, input logic exp_err,
                       input logic [3:0] new_lv, input logic [7:0] exp_code);
    logic par;
    par = par_ok ? ~^d : ^d;
    fall_bit(1'b0);
    rise();
    for (int i = 0; i < 8; i++) begin
      fall_bit(d[i]);
      rise();
    end
    fall_bit(par);
    rise();
    fall_bit(stop);
    // Two sync flops: fall seen in the 2nd cycle, outputs registered one later.
    wait_neg(2);
    chk({tag, "/pre_rdy"}, 32'(scan_ready), 32'(0));
    chk({tag, "/pre_err"}, 32'(frame_err), 32'(0));
    chk({tag, "/pre_lv"}, 32'({p1_up, p1_down, p2_up, p2_down}), 32'(lv));
    wait_neg(1);
    chk({tag, "/rdy"}, 32'(scan_ready), 32'(exp_rdy));
    chk({tag, "/err"}, 32'(frame_err), 32'(exp_err));
    chk({tag, "/lv"}, 32'({p1_up, p1_down, p2_up, p2_down}), 32'(new_lv));
    chk({tag, "/code"}, 32'(scan_code), 32'(exp_code));
    wait_neg(1);
    chk({tag, "/rdy_end"}, 32'(scan_ready), 32'(0));
    chk({tag, "/err_end"}, 32'(frame_err), 32'(0));
    lv = new_lv;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    wait_neg(HALF);
  endtask

  initial begin
    logic [7:0] e0;
    e0      = 8'hE0;
    reset   = 1'b1;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    lv      = 4'b0000;
    wait_neg(3);
    chk("rst/lv", 32'({p1_up, p1_down, p2_up, p2_down}), 32'(0));
    chk("rst/code", 32'(scan_code), 32'(0));
    chk("rst/rdy", 32'(scan_ready), 32'(0));
    chk("rst/err", 32'(frame_err), 32'(0));
    reset = 1'b0;
    wait_neg(5);

    // W make/break
    frame("p1_make",  8'h1D, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1000, 8'h1D);
    frame("brk_pfx",  8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1000, 8'hF0);
    frame("p1_brk",   8'h1D, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 8'h1D);

    // Up arrow via E0, plain 75 ignored, E0 F0 75 release
    frame("ext_pfx",  8'hE0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 8'hE0);
    frame("p2u_make", 8'h75, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0010, 8'h75);
    frame("plain75",  8'h75, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0010, 8'h75);
    frame("ext_pfx2", 8'hE0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0010, 8'hE0);
    frame("brk_pfx2", 8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0010, 8'hF0);
    frame("p2u_brk",  8'h75, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 8'h75);

    // S held while Down arrow pressed
    frame("p1d_make", 8'h1B, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0100, 8'h1B);
    frame("ext_pfx3", 8'hE0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0100, 8'hE0);
    frame("p2d_make", 8'h72, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0101, 8'h72);

    // Release S, bad-parity S ignored, then good S
    frame("brk_pfx3", 8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0101, 8'hF0);
    frame("p1d_brk",  8'h1B, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 8'h1B);
    frame("bad_par",  8'h1B, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 8'h1B);
    frame("p1d_again",8'h1B, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0101, 8'h1B);

    // Timeout: start + 4 data bits of 1D, then ps2_clk parked high
    snap_rdy = rdy_cnt;
    snap_err = err_cnt;
    fall_bit(1'b0);
    rise();
    fall_bit(1'b1); rise();
    fall_bit(1'b0); rise();
    fall_bit(1'b1); rise();
    fall_bit(1'b1);
    for (int k = 1; k <= 5004; k++) begin
      @(negedge clk);
      if (k == HALF) ps2_clk = 1'b1;
      if (k == 5002) chk("to/before", 32'(frame_err), 32'(0));
      if (k == 5003) chk("to/pulse", 32'(frame_err), 32'(1));
      if (k == 5004) chk("to/after", 32'(frame_err), 32'(0));
    end
    ps2_dat = 1'b1;
    wait_neg(HALF);
    chk("to/err_once", 32'(err_cnt), 32'(snap_err + 1));
    chk("to/no_rdy", 32'(rdy_cnt), 32'(snap_rdy));
    chk("to/idle", 32'(u_dut.u_rx.state_q), 32'(IDLE));
    chk("to/lv", 32'({p1_up, p1_down, p2_up, p2_down}), 32'(lv));
    frame("after_to", 8'h1D, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1101, 8'h1D);

    // Release W, then F0 + corrupted frame must not turn the next 1D into a break
    frame("brk_pfx4", 8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1101, 8'hF0);
    frame("p1u_brk",  8'h1D, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0101, 8'h1D);
    frame("brk_pfx5", 8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0101, 8'hF0);
    frame("bad_stop", 8'h1D, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0101, 8'hF0);
    frame("make_not_brk", 8'h1D, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1101, 8'h1D);

    // Reset after the 6th data bit of E0, then plain 75
    snap_rdy = rdy_cnt;
    fall_bit(1'b0);
    rise();
    for (int i = 0; i < 6; i++) begin
      fall_bit(e0[i]);
      rise();
    end
    reset = 1'b1;
    wait_neg(2);
    chk("midrst/lv", 32'({p1_up, p1_down, p2_up, p2_down}), 32'(0));
    chk("midrst/code", 32'(scan_code), 32'(0));
    reset   = 1'b0;
    ps2_dat = 1'b1;
    lv      = 4'b0000;
    wait_neg(5);
    frame("post_rst75", 8'h75, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 8'h75);
    chk("midrst/one_rdy", 32'(rdy_cnt), 32'(snap_rdy + 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
